tick_timer_scheduler: RTL and testbench
=======================================

Name: tick_timer_scheduler

Overview:
- Shares one base-tick prescaler among NUM_CH independent software-programmable timer channels.
- Each channel counts base ticks and, on expiry, emits a one-cycle pulse and toggles a square-wave level.
- Sits between the register/control logic (configuration handshake) and the display, LED and debounce consumers that need slow periodic enables.
- Replaces per-consumer free-running dividers with one shared prescaler.

Parameters:
- CLK_HZ, 125_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, base tick rate in Hz. DIV = CLK_HZ/TICK_HZ; integer division required; DIV >= 2.
- NUM_CH, 4, number of timer channels (1..16).
- PERIOD_W, 16, width of the per-channel period in base ticks.

Ports:
- clk_in  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  global run enable; 0 clears the prescaler and freezes all channels.
- cfg_valid  in  1  configuration command valid.
- cfg_ready  out  1  block can accept a command.
- cfg_cmd  in  1  0 = STOP, 1 = START.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  1  0 = one-shot, 1 = periodic (used on START only).
- cfg_period  in  PERIOD_W  period in base ticks (used on START only).
- cfg_err  out  1  one-cycle pulse: command rejected.
- tick  out  1  one-cycle base tick pulse at TICK_HZ.
- ch_pulse  out  NUM_CH  one-cycle expiry pulse per channel.
- ch_level  out  NUM_CH  per-channel square wave; toggles on each expiry.
- ch_active  out  NUM_CH  channel running.

Behaviour:
- Reset (async assert, sync release): prescaler = 0, all channel counters = 0, tick = 0, ch_pulse = 0, ch_level = 0, ch_active = 0, cfg_err = 0, cfg_ready = 1.
- Prescaler:
  - Counter width clog2(DIV); counts 0..DIV-1 while en = 1.
  - At DIV-1 it wraps to 0, and tick is registered high for the next cycle. Tick period is exactly DIV cycles.
  - en = 0: counter forced to 0, no ticks, channel state held.
- Channel update (evaluated in a cycle where tick = 1 and ch_active[i] = 1):
  - If cnt == period-1: cnt <= 0; ch_pulse[i] = 1 in the following cycle; ch_level[i] toggles in that same cycle.
  - Additionally, in one-shot mode, ch_active[i] <= 0.
  - Otherwise cnt <= cnt+1.
  - Expiry latency is therefore one cycle after the tick pulse.
  - period = 1 expires on every tick.
- Handshake:
  - A command is accepted when cfg_valid && cfg_ready.
  - cfg_ready drops for exactly one cycle after each acceptance (BUSY), so at most one command every 2 cycles.
  - cfg_valid is ignored while cfg_ready = 0.
- Controller FSM: IDLE (cfg_ready = 1) -> accept -> BUSY (cfg_ready = 0) -> IDLE. Reset returns the FSM to IDLE.
- START: cnt <= 0, period/mode latched, ch_active <= 1, ch_level <= 0.
  - Restarting an already-active channel reloads it.
- STOP: ch_active <= 0, cnt <= 0, ch_level holds its value.
  - STOP on an idle channel is a no-op (no error).
- Rejection: cfg_err pulses one cycle after acceptance, with no state change, when cfg_ch >= NUM_CH, or when START has cfg_period == 0.
- Simultaneous events: if a command hits a channel in the same cycle as its tick evaluation, the command wins. No expiry pulse and no level toggle occur from that tick. Other channels update normally.
- Wrap-around: the counter never exceeds period-1. The maximum period is 2^PERIOD_W - 1 ticks.
- Reset mid-operation: all channels stop at once. Outputs return to their reset values asynchronously.

Decomposition:
- Shared package holds:
  - CMD_STOP and CMD_START constants.
  - MODE_ONESHOT and MODE_PERIODIC constants.
  - The controller state encoding (ST_IDLE, ST_BUSY).
  - A clog2 helper function.
- One sub-module: tick_timer_channel (counter, mode, period, level, pulse), instantiated NUM_CH times via generate.
- Prescaler and the handshake FSM stay in the top module.

Test Plan (CLK_HZ = 10, TICK_HZ = 1, so DIV = 10; NUM_CH = 4):
- Reset then en = 1 for 35 cycles -> tick high on cycles 10, 20 and 30 after en rises; all ch outputs stay 0; cfg_ready = 1.
- START ch0, periodic, period 3 -> ch_pulse[0] exactly every 30 cycles, each one cycle after every third tick. ch_level[0] toggles on each pulse (60-cycle square wave).
- START ch1, one-shot, period 2 -> a single ch_pulse[1] one cycle after the 2nd tick. ch_active[1] then falls to 0 and no further pulses occur.
- START with cfg_ch = 5, then START ch2 with period 0 -> cfg_err pulses once per command; ch_active unchanged; cfg_ready low for one cycle after each acceptance.
- Back-to-back valid for two cycles -> only the first command is accepted. STOP ch0 issued in the same cycle ch0 would expire -> no pulse, ch_active[0] = 0, level held.
- Assert reset_n = 0 mid-count with 2 channels active -> all outputs 0 immediately. After release, no pulses occur until a new START.

Source files
------------

// File: rtl/tick_timer_scheduler_pkg.sv
// Shared constants, controller state encoding and helpers
// for the tick timer scheduler.
package tick_timer_scheduler_pkg;

   localparam logic CMD_STOP      = 1'b0;
   localparam logic CMD_START     = 1'b1;
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } ctl_state_e;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_timer_channel.sv
// One timer channel: counts base ticks, pulses and toggles
// its level on expiry. A command in the same cycle beats the tick.
module tick_timer_channel
   import tick_timer_scheduler_pkg::*;
#(
   parameter int PERIOD_W = 16
) (
   input  logic                clk_in,
   input  logic                reset_n,
   input  logic                tick,
   input  logic                start,
   input  logic                stop,
   input  logic                mode,
   input  logic [PERIOD_W-1:0] period,
   output logic                pulse,
   output logic                level,
   output logic                active
);

   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] last;
   logic                mode_q;

   assign last = period_q - PERIOD_W'(1);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         period_q <= '0;
         mode_q   <= MODE_ONESHOT;
         pulse    <= 1'b0;
         level    <= 1'b0;
         active   <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (start) begin
            cnt      <= '0;
            period_q <= period;
            mode_q   <= mode;
            active   <= 1'b1;
            level    <= 1'b0;
         end else if (stop) begin
            cnt    <= '0;
            active <= 1'b0;
         end else if (tick && active) begin
            if (cnt == last) begin
               cnt   <= '0;
               pulse <= 1'b1;
               level <= ~level;
               if (mode_q == MODE_ONESHOT)
                  active <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tick_timer_scheduler.sv
// Shared base-tick prescaler, config handshake controller
// and NUM_CH timer channels.
module tick_timer_scheduler
   import tick_timer_scheduler_pkg::*;
#(
   parameter int CLK_HZ   = 125_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = 16
) (
   input  logic                clk_in,
   input  logic                reset_n,
   input  logic                en,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic                cfg_cmd,
   input  logic [3:0]          cfg_ch,
   input  logic                cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic                cfg_err,
   output logic                tick,
   output logic [NUM_CH-1:0]   ch_pulse,
   output logic [NUM_CH-1:0]   ch_level,
   output logic [NUM_CH-1:0]   ch_active
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = clog2(DIV);

   logic [PW-1:0] presc;
   ctl_state_e    state_q;
   ctl_state_e    state_d;
   logic          accept;
   logic          reject;
   logic          go;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (!en) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc == PW'(DIV - 1)) begin
         presc <= '0;
         tick  <= 1'b1;
      end else begin
         presc <= presc + 1'b1;
         tick  <= 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cfg_err <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_err <= accept && reject;
      end
   end

   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               accept  = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Out-of-range channel or a zero period leaves all state alone
   assign reject = ({1'b0, cfg_ch} >= 5'(NUM_CH)) ||
                   (cfg_cmd == CMD_START && cfg_period == '0);
   assign go     = accept && !reject;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = go && (cfg_ch == 4'(i));
      tick_timer_channel #(
         .PERIOD_W(PERIOD_W)
      ) u_ch (
         .clk_in (clk_in),
         .reset_n(reset_n),
         .tick   (tick),
         .start  (sel && cfg_cmd == CMD_START),
         .stop   (sel && cfg_cmd == CMD_STOP),
         .mode   (cfg_mode),
         .period (cfg_period),
         .pulse  (ch_pulse[i]),
         .level  (ch_level[i]),
         .active (ch_active[i])
      );
   end

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Scoreboard bench for tick_timer_scheduler with DIV = 10
// and four channels.
module tb_tick_timer_scheduler;
   import tick_timer_scheduler_pkg::*;

   localparam int NCH = 4;

   logic        clk_in = 1'b0;
   logic        reset_n;
   logic        en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_cmd;
   logic [3:0]  cfg_ch;
   logic        cfg_mode;
   logic [15:0] cfg_period;
   logic        cfg_err;
   logic        tick;
   logic [3:0]  ch_pulse;
   logic [3:0]  ch_level;
   logic [3:0]  ch_active;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int e0;
   int rr;

   int tq[$];
   int eq[$];
   int pc[NCH][$];
   bit pl[NCH][$];

   tick_timer_scheduler #(
      .CLK_HZ  (10),
      .TICK_HZ (1),
      .NUM_CH  (NCH),
      .PERIOD_W(16)
   ) dut (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_cmd   (cfg_cmd),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_period(cfg_period),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .ch_pulse  (ch_pulse),
      .ch_level  (ch_level),
      .ch_active (ch_active)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic miss(input string nm, input int c);
      total++;
      bad++;
      $display("FAIL %s: got none want event at cyc %0d (now %0d)",
               nm, c, cyc);
   endtask

   task automatic extra(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got unexpected event want none at cyc %0d",
               nm, cyc);
   endtask

   // Monitor: pops the expected event whenever the DUT emits one
   always @(negedge clk_in) begin
      if (tick) begin
         if (tq.size() == 0) extra("tick");
         else chk("tick_cyc", cyc, tq.pop_front());
      end
      while (tq.size() > 0 && tq[0] < cyc)
         miss("tick", tq.pop_front());
      if (cfg_err) begin
         if (eq.size() == 0) extra("cfg_err");
         else chk("err_cyc", cyc, eq.pop_front());
      end
      while (eq.size() > 0 && eq[0] < cyc)
         miss("cfg_err", eq.pop_front());
      for (int i = 0; i < NCH; i++) begin
         if (ch_pulse[i]) begin
            if (pc[i].size() == 0) extra($sformatf("pulse%0d", i));
            else begin
               chk($sformatf("pulse%0d_cyc", i), cyc, pc[i].pop_front());
               chk($sformatf("pulse%0d_lvl", i), 32'(ch_level[i]),
                   32'(pl[i].pop_front()));
            end
         end
         while (pc[i].size() > 0 && pc[i][0] < cyc) begin
            miss($sformatf("pulse%0d", i), pc[i].pop_front());
            void'(pl[i].pop_front());
         end
      end
   end

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk_in);
   endtask

   task automatic do_cmd(input logic c, input logic [3:0] ch,
                         input logic m, input logic [15:0] p);
      cfg_cmd    = c;
      cfg_ch     = ch;
      cfg_mode   = m;
      cfg_period = p;
      cfg_valid  = 1'b1;
      @(negedge clk_in);
      cfg_valid  = 1'b0;
   endtask

   task automatic exp_pulse(input int ch, input int c, input bit l);
      pc[ch].push_back(c);
      pl[ch].push_back(l);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      en         = 1'b0;
      cfg_valid  = 1'b0;
      cfg_cmd    = CMD_STOP;
      cfg_ch     = 4'd0;
      cfg_mode   = MODE_ONESHOT;
      cfg_period = 16'd0;
      repeat (3) @(negedge clk_in);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_pulse", 32'(ch_pulse), 0);
      chk("rst_level", 32'(ch_level), 0);
      chk("rst_active", 32'(ch_active), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_ready", 32'(cfg_ready), 1);
      reset_n = 1'b1;
      @(negedge clk_in);
      en = 1'b1;
      e0 = cyc;
      for (int k = 1; k <= 17; k++) tq.push_back(e0 + 10 * k);

      wait_to(e0 + 35);
      chk("idle_active", 32'(ch_active), 0);
      chk("idle_level", 32'(ch_level), 0);
      chk("idle_ready", 32'(cfg_ready), 1);

      exp_pulse(0, e0 + 61, 1'b1);
      exp_pulse(0, e0 + 91, 1'b0);
      exp_pulse(0, e0 + 121, 1'b1);
      do_cmd(CMD_START, 4'd0, MODE_PERIODIC, 16'd3);
      chk("busy_ready0", 32'(cfg_ready), 0);
      chk("start0_active", 32'(ch_active), 4'b0001);

      wait_to(e0 + 37);
      exp_pulse(1, e0 + 51, 1'b1);
      do_cmd(CMD_START, 4'd1, MODE_ONESHOT, 16'd2);

      wait_to(e0 + 45);
      eq.push_back(e0 + 46);
      do_cmd(CMD_START, 4'd5, MODE_PERIODIC, 16'd3);
      chk("busy_ready1", 32'(cfg_ready), 0);
      chk("badch_active", 32'(ch_active), 4'b0011);

      wait_to(e0 + 47);
      eq.push_back(e0 + 48);
      do_cmd(CMD_START, 4'd2, MODE_PERIODIC, 16'd0);
      chk("busy_ready2", 32'(cfg_ready), 0);
      chk("zero_active", 32'(ch_active), 4'b0011);

      wait_to(e0 + 53);
      chk("oneshot_active", 32'(ch_active), 4'b0001);
      chk("oneshot_level", 32'(ch_level), 4'b0010);

      wait_to(e0 + 55);
      exp_pulse(3, e0 + 101, 1'b1);
      exp_pulse(3, e0 + 151, 1'b0);
      cfg_cmd    = CMD_START;
      cfg_ch     = 4'd3;
      cfg_mode   = MODE_PERIODIC;
      cfg_period = 16'd5;
      cfg_valid  = 1'b1;
      @(negedge clk_in);
      cfg_ch     = 4'd2;
      cfg_period = 16'd1;
      @(negedge clk_in);
      cfg_valid  = 1'b0;
      chk("b2b_active", 32'(ch_active), 4'b1001);

      wait_to(e0 + 62);
      chk("lvl0_high", 32'(ch_level), 4'b0011);

      wait_to(e0 + 150);
      do_cmd(CMD_STOP, 4'd0, MODE_ONESHOT, 16'd0);
      wait_to(e0 + 152);
      chk("stop_active", 32'(ch_active), 4'b1000);
      chk("stop_level", 32'(ch_level), 4'b0011);

      wait_to(e0 + 153);
      do_cmd(CMD_START, 4'd2, MODE_PERIODIC, 16'd4);
      chk("two_active", 32'(ch_active), 4'b1100);

      wait_to(e0 + 175);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_tick", 32'(tick), 0);
      chk("mid_rst_pulse", 32'(ch_pulse), 0);
      chk("mid_rst_level", 32'(ch_level), 0);
      chk("mid_rst_active", 32'(ch_active), 0);
      chk("mid_rst_ready", 32'(cfg_ready), 1);
      repeat (3) @(negedge clk_in);
      reset_n = 1'b1;
      rr = cyc;
      for (int k = 1; k <= 4; k++) tq.push_back(rr + 10 * k);

      wait_to(rr + 45);
      chk("post_active", 32'(ch_active), 0);
      chk("post_level", 32'(ch_level), 0);
      chk("left_tick", 32'(tq.size()), 0);
      chk("left_err", 32'(eq.size()), 0);
      for (int i = 0; i < NCH; i++)
         chk($sformatf("left_pulse%0d", i), 32'(pc[i].size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
